// File: rtl/nios_pio_pkg.sv
// Shared constants and types for the Nios PIO slaves.
package nios_pio_pkg;
  localparam int PIO_WIDTH_DEF = 20;

  localparam logic [1:0] PIO_ADDR_DATA    = 2'd0;
  localparam logic [1:0] PIO_ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] PIO_ADDR_EDGECAP = 2'd3;

  typedef struct packed {
    logic [1:0]  address;
    logic        wr;
    logic [31:0] wdata;
  } pio_req_t;
endpackage

// File: rtl/pio_in_debounce.sv
// Stability filter: accepts a new synchronized bus value only after it has
// been steady for DEBOUNCE_CYCLES cycles. One counter is shared by all bits.
module pio_in_debounce #(
  parameter int WIDTH           = 20,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] sync2,
  output logic [WIDTH-1:0] data_in
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync_last;
  logic [CW-1:0]    cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_last <= '0;
      data_in   <= '0;
      cnt       <= '0;
    end else begin
      sync_last <= sync2;
      if (sync2 != sync_last) begin
        cnt <= '0;
      end else if (sync2 != data_in) begin
        if (cnt == CNT_LAST) begin
          data_in <= sync2;
          cnt     <= '0;
        end else if (cnt != '1) begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end
endmodule

// File: rtl/nios_system_pio_in.sv
// Avalon-MM input PIO: synchronizer, rising-edge capture, maskable level irq.
// Optional debounce filter is compiled in with `define PIO_IN_DEBOUNCE_EN.
module nios_system_pio_in
  import nios_pio_pkg::*;
#(
  parameter int WIDTH           = PIO_WIDTH_DEF,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);
  pio_req_t         req;
  logic [WIDTH-1:0] sync1, sync2, data_in, data_prev;
  logic [WIDTH-1:0] irqmask, edgecap, rise, clr;
  logic             wdata_unused;

  assign req          = '{address: address, wr: chipselect & ~write_n, wdata: writedata};
  assign wdata_unused = ^req.wdata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= in_port;
      sync2 <= sync1;
    end
  end

`ifdef PIO_IN_DEBOUNCE_EN
  pio_in_debounce #(
    .WIDTH           (WIDTH),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk     (clk),
    .reset_n (reset_n),
    .sync2   (sync2),
    .data_in (data_in)
  );
`else
  localparam int DEBOUNCE_UNUSED = DEBOUNCE_CYCLES;
  assign data_in = sync2;
`endif

  assign rise = data_in & ~data_prev;
  assign clr  = (req.wr && req.address == PIO_ADDR_EDGECAP) ? req.wdata[WIDTH-1:0] : '0;

  // Set has priority over write-1-to-clear so a coincident edge is never lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_prev <= '0;
      irqmask   <= '0;
      edgecap   <= '0;
    end else begin
      data_prev <= data_in;
      edgecap   <= (edgecap & ~clr) | rise;
      if (req.wr && req.address == PIO_ADDR_IRQMASK) irqmask <= req.wdata[WIDTH-1:0];
    end
  end

  assign irq = |(edgecap & irqmask);

  always_comb begin
    readdata = '0;
    case (address)
      PIO_ADDR_DATA:    readdata[WIDTH-1:0] = data_in;
      PIO_ADDR_IRQMASK: readdata[WIDTH-1:0] = irqmask;
      PIO_ADDR_EDGECAP: readdata[WIDTH-1:0] = edgecap;
      default:          readdata = '0;
    endcase
  end
endmodule

// File: doc/nios_system_pio_in.md
# nios_system_pio_in

Avalon-MM slave input port that samples a WIDTH-bit level bus from game-table hardware into the Nios system. It is the read-side counterpart of the system's output PIO ports. The block synchronizes the bus, captures rising edges per bit, and raises a maskable interrupt. Software reads the live level, programs the interrupt mask, and clears captured edges.

## Interface
- WIDTH, 20, width of in_port and of all data registers (1..32)
- DEBOUNCE_CYCLES, 16, consecutive stable cycles required before a new value is accepted (only with debounce compiled in; ≥1)
- clk  input  1  system clock
- reset_n  input  1  asynchronous, active-low reset
- address  input  2  register select
- chipselect  input  1  slave select
- write_n  input  1  active-low write strobe
- writedata  input  32  write data; bits above WIDTH ignored
- in_port  input  WIDTH  asynchronous level inputs from table hardware
- readdata  output  32  read data, zero-extended above WIDTH
- irq  output  1  level interrupt to the CPU

## Operation
- Register map:
  - 0 DATA: filtered level, read-only.
  - 1: reserved; reads 0, writes ignored.
  - 2 IRQMASK: read/write, bits [WIDTH-1:0].
  - 3 EDGECAP: read, write-1-to-clear per bit.
- Write qualifier is chipselect & ~write_n. A write to address 0 or 1 has no effect.
- readdata is combinational from address with zero wait states. It is independent of chipselect and read side-effect free.
- in_port passes through a 2-flop synchronizer (sync1 → sync2) on every bit.
- data_in is sync2. With debounce compiled in, data_in is the debounced value instead.
- Edge detection:
  - data_prev is a registered copy of data_in.
  - rise = data_in & ~data_prev.
  - EDGECAP[i] sets when rise[i]=1.
- Simultaneous clear and new edge on the same bit in the same cycle: the edge wins and the bit stays 1.
- irq = |(EDGECAP & IRQMASK). It is combinational from registers, so there are no glitches from in_port.
- Reset values:
  - sync1, sync2, data_in, data_prev, IRQMASK and EDGECAP are 0.
  - irq and readdata (address 0) are 0.
- An input held high through reset produces exactly one captured rising edge after reset release. Software clears EDGECAP during init.
- Reset asserted mid-operation clears all state immediately, including any partial debounce count.

## Timing
- Without debounce, a level change of in_port that meets setup before clk edge N:
  - is visible on DATA after edge N+1;
  - sets EDGECAP after edge N+2;
  - asserts irq (if masked in) in the same cycle EDGECAP sets.
- A write to IRQMASK or EDGECAP takes effect on the clock edge of the write. irq updates in the following cycle.
- Pulses shorter than one clk period may be missed. This is not an error.

## Configuration
- PIO_IN_DEBOUNCE_EN defined:
  - A single shared counter compares sync2 against data_in.
  - Any cycle with sync2 ≠ the value seen last cycle reloads the counter to 0.
  - When sync2 ≠ data_in and the counter reaches DEBOUNCE_CYCLES-1, data_in ← sync2 and the counter resets.
  - Latency from in_port to DATA is 2 + DEBOUNCE_CYCLES cycles. EDGECAP sets one cycle later.
  - Counter width is $clog2(DEBOUNCE_CYCLES)+1. The counter saturates and never wraps.
- PIO_IN_DEBOUNCE_EN undefined: data_in = sync2 and no counter is instantiated.

## Structure
- Shared package nios_pio_pkg:
  - address constants PIO_ADDR_DATA=0, PIO_ADDR_IRQMASK=2, PIO_ADDR_EDGECAP=3;
  - default PIO width constant.
- Sub-module pio_in_debounce (WIDTH, DEBOUNCE_CYCLES).
  - It contains the stability counter and holds data_in.
  - It is instantiated only under PIO_IN_DEBOUNCE_EN.

## Test plan
- Reset with in_port=0, then drive 20'h00005 → DATA reads 0x00000005 after 2 edges. EDGECAP reads 0x5 one cycle later. irq stays 0 (mask 0).
- Write IRQMASK=0x4, then raise bit 2 → irq=1 in the cycle EDGECAP[2] sets. Write EDGECAP=0x4 → irq=0 next cycle and EDGECAP=0x1 remains.
- Write EDGECAP=0x1 in the same cycle a new rise on bit 0 reaches the edge detector → EDGECAP[0] stays 1.
- Falling edge on bit 0 (1→0) → DATA bit clears and EDGECAP is unchanged.
- With PIO_IN_DEBOUNCE_EN and DEBOUNCE_CYCLES=4:
  - toggle bit 1 for 3 cycles then return → DATA and EDGECAP unchanged;
  - hold high for 4 cycles → DATA bit 1 = 1 at 2+4 cycles.
- Assert reset_n=0 mid-debounce with IRQMASK=0xFFFFF → irq, DATA, EDGECAP and IRQMASK read 0 after release.
